lsu_controller: RTL and testbench

Load/store sequencer between the RV32I datapath and a data memory bus with a req/ack handshake. Memory access is no longer single-cycle. The block:
- detects a load or store from the decoder;
- stalls the PC register and register-file write until the bus transaction completes;
- generates word-aligned addresses, byte enables and lane-shifted write data;
- returns lane-aligned read data to the datapath's load extender.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_lane_align.sv | 33 +++
 rtl/lsu_controller.sv | 132 +++++++++++++
 tb/tb_lsu_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: FSM states, funct3 encodings and
// the access-size decode.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } lsu_state_e;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } lsu_size_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Undefined funct3 encodings fall through to a word access.
  function automatic lsu_size_e ls_size(input logic [2:0] funct3);
    case (funct3)
      LS_B, LS_BU: return SzByte;
      LS_H, LS_HU: return SzHalf;
      default:     return SzWord;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: alignment check, byte enables, store-data shift
// into its byte lane and load-data shift back down to bit 0.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  load_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rdata_raw,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_lane
);

  always_comb begin
    aligned = 1'b1;
    be      = 4'b1111;
    case (ls_size(load_store))
      SzByte: be = 4'b0001 << addr_lo;
      SzHalf: begin
        aligned = ~addr_lo[0];
        be      = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: aligned = (addr_lo == 2'b00);
    endcase
  end

  assign wdata_lane = wdata << {addr_lo, 3'b000};
  assign rdata_lane = rdata_raw >> {rd_off, 3'b000};

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer with req/ack bus handshake; stalls the pipeline until
// the bus transaction completes. Define LSU_TIMEOUT_EN to add a BUSY timeout.
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  load_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  lsu_state_e  state_q;
  logic [1:0]  off_q;
  logic        access;
  logic        aligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rdata_next;

  assign access = mem_read | mem_write;

  // Read shift uses the offset captured at launch, not the live address.
  lsu_lane_align u_lane_align (
    .load_store (load_store),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .rd_off     (off_q),
    .rdata_raw  (bus_rdata),
    .aligned    (aligned),
    .be         (be_next),
    .wdata_lane (wdata_next),
    .rdata_lane (rdata_next)
  );

  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    if (reset) begin
      case (state_q)
        StIdle: begin
          stall    = access & aligned;
          misalign = access & ~aligned;
        end
        StBusy:  stall = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      off_q     <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      rdata_out <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= 8'h0;
      bus_err   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (access && aligned) begin
            state_q   <= StBusy;
            off_q     <= addr[1:0];
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
          end
        end
        StBusy: begin
          if (bus_ack) begin
            rdata_out <= rdata_next;
            bus_req   <= 1'b0;
            state_q   <= StDone;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= 8'h0;
`endif
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == TimeoutLast) begin
            rdata_out <= 32'h0;
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
            cnt_q     <= 8'h0;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
`ifdef LSU_TIMEOUT_EN
          bus_err <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: the driver pushes expected bus requests
// and completions, a negedge monitor pops and compares them.
module tb_lsu_controller;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  load_store = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        stall, misalign, bus_req, bus_we, bus_err;
  logic [31:0] rdata_out, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

`ifdef LSU_TIMEOUT_EN
  localparam int Tmo = 4;
`else
  localparam int Tmo = 0;
`endif

  lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .load_store (load_store),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata_out  (rdata_out),
    .misalign   (misalign),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } cpl_t;

  req_t req_q[$];
  cpl_t cpl_q[$];
  int   mis_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected (t=%0t)", name, $time);
  endtask

  function automatic int access_bytes(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  // Called at the start of an IDLE cycle (posedge + 1); returns at the start of
  // the next IDLE cycle.
  task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input int w,
                        input logic [31:0] rd_word);
    int   n;
    int   off;
    req_t r;
    cpl_t c;
    n   = access_bytes(f);
    off = int'(a[1:0]);
    mem_read   = rd;
    mem_write  = wr;
    load_store = f;
    addr       = a;
    wdata      = d;
    if (off % n != 0) begin
      mis_q.push_back(1);
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      return;
    end
    r.we    = wr;
    r.addr  = a & 32'hFFFF_FFFC;
    r.be    = 4'(((1 << n) - 1) << off);
    r.wdata = d << (8 * off);
    req_q.push_back(r);
    @(posedge clk); #1;
    if (Tmo != 0 && w >= Tmo) begin
      c.rdata  = 32'h0;
      c.err    = 1'b1;
      c.stalls = 1 + Tmo;
      cpl_q.push_back(c);
      repeat (Tmo) begin
        addr = $urandom; wdata = $urandom; bus_rdata = $urandom;
        @(posedge clk); #1;
      end
    end else begin
      repeat (w) begin
        addr = $urandom; wdata = $urandom; bus_rdata = $urandom;
        @(posedge clk); #1;
      end
      bus_ack   = 1'b1;
      bus_rdata = rd_word;
      c.rdata   = rd_word >> (8 * off);
      c.err     = 1'b0;
      c.stalls  = 2 + w;
      cpl_q.push_back(c);
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    // DONE cycle: a pending access must not launch until IDLE.
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    load_store = LS_B;
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  initial begin : monitor
    logic        prev_req;
    int          stall_cnt;
    logic [31:0] hold;
    req_t        cur;
    cpl_t        c;
    prev_req  = 1'b0;
    stall_cnt = 0;
    hold      = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_req  = 1'b0;
        stall_cnt = 0;
        hold      = 32'h0;
        check32("reset_bus_req", bus_req, 1'b0);
        check32("reset_stall", stall, 1'b0);
        check32("reset_misalign", misalign, 1'b0);
      end else begin
        if (stall) stall_cnt++;
        if (misalign) begin
          if (mis_q.size() == 0) fail_event("unexpected_misalign");
          else begin
            void'(mis_q.pop_front());
            check32("misalign_stall", stall, 1'b0);
            check32("misalign_req", bus_req, 1'b0);
          end
        end
        if (bus_req) begin
          if (!prev_req) begin
            if (req_q.size() == 0) fail_event("unexpected_req");
            else cur = req_q.pop_front();
          end
          check32("bus_we", bus_we, cur.we);
          check32("bus_addr", bus_addr, cur.addr);
          check32("bus_be", bus_be, cur.be);
          check32("bus_wdata", bus_wdata, cur.wdata);
          check32("busy_stall", stall, 1'b1);
          check32("busy_err", bus_err, 1'b0);
        end else if (prev_req) begin
          if (cpl_q.size() == 0) fail_event("unexpected_done");
          else begin
            c = cpl_q.pop_front();
            check32("rdata_out", rdata_out, c.rdata);
            check32("done_err", bus_err, c.err);
            check32("done_stall", stall, 1'b0);
            check32("stall_cycles", stall_cnt, c.stalls);
            hold = c.rdata;
          end
          stall_cnt = 0;
        end else begin
          check32("idle_rdata_hold", rdata_out, hold);
          check32("idle_err", bus_err, 1'b0);
          if (!stall) stall_cnt = 0;
        end
        prev_req = bus_req;
      end
    end
  end

  initial begin : driver
    logic [1:0] rw;
    int         g;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_bus_addr", bus_addr, 32'h0);
    check32("rst_bus_be", bus_be, 4'h0);
    check32("rst_bus_wdata", bus_wdata, 32'h0);
    check32("rst_rdata_out", rdata_out, 32'h0);
    check32("rst_bus_we", bus_we, 1'b0);
    check32("rst_bus_err", bus_err, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b0, 1'b1, LS_W, 32'h100, 32'hDEADBEEF, 0, $urandom);
    do_txn(1'b0, 1'b1, LS_B, 32'h103, 32'h000000AB, 1, $urandom);
    do_txn(1'b1, 1'b0, LS_H, 32'h102, 32'h0, 3, 32'h8001_1234);
    do_txn(1'b1, 1'b0, LS_W, 32'h101, 32'h0, 0, 32'h0);
    do_txn(1'b1, 1'b1, 3'b111, 32'h204, 32'h1234_5678, 2, $urandom);

    // Reset in the middle of BUSY, then a late ack after release.
    mem_read   = 1'b1;
    load_store = LS_W;
    addr       = 32'h200;
    req_q.push_back('{we: 1'b0, addr: 32'h200, be: 4'hF, wdata: 32'h0});
    wdata      = 32'h0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check32("async_rst_req", bus_req, 1'b0);
    check32("async_rst_stall", stall, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    mem_read  = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_ack = 1'b0;
    check32("late_ack_req", bus_req, 1'b0);
    do_txn(1'b1, 1'b0, LS_BU, 32'h301, 32'h0, 0, 32'hA1B2_C3D4);

    for (int i = 0; i < 300; i++) begin
      rw = 2'($urandom_range(1, 3));
      do_txn(rw[0], rw[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 5), $urandom);
      g = $urandom_range(0, 2);
      repeat (g) begin
        bus_ack   = 1'($urandom);
        bus_rdata = $urandom;
        @(posedge clk); #1;
      end
      bus_ack = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check32("req_q_drained", req_q.size(), 0);
    check32("cpl_q_drained", cpl_q.size(), 0);
    check32("mis_q_drained", mis_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
